decode_stage: RTL and testbench



---
 rtl/decode_pkg.sv | 75 +++++++
 rtl/decode_regfile.sv | 55 +++++
 rtl/decode_stage.sv | 101 ++++++++++
 tb/tb_decode_stage.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared constants and control-bundle types for the ID stage.
//   - Opcode constants for the supported instruction classes.
//   - ALU_OP_* encodings carried in the EX control bundle.
//   - WB/M/EX bundle widths and packed struct views of each bundle.
//   - decode_ctrl(): opcode -> control bundle (unsupported opcodes -> bubble).
package decode_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned WB_W   = 2;
  localparam int unsigned M_W    = 3;
  localparam int unsigned EX_W   = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } m_ctrl_t;

  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
  } ex_ctrl_t;

  typedef struct packed {
    wb_ctrl_t wb;
    m_ctrl_t  m;
    ex_ctrl_t ex;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.wb.reg_write = 1'b1;
        c.ex.reg_dst   = 1'b1;
        c.ex.alu_op    = ALU_OP_FUNCT;
      end
      OP_LW: begin
        c.wb.reg_write  = 1'b1;
        c.wb.mem_to_reg = 1'b1;
        c.m.mem_read    = 1'b1;
        c.ex.alu_op     = ALU_OP_ADD;
        c.ex.alu_src    = 1'b1;
      end
      OP_SW: begin
        c.m.mem_write = 1'b1;
        c.ex.alu_op   = ALU_OP_ADD;
        c.ex.alu_src  = 1'b1;
      end
      OP_BEQ: begin
        c.m.branch  = 1'b1;
        c.ex.alu_op = ALU_OP_SUB;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: NREGS x XLEN general register file.
//   clk_i          rising-edge clock
//   rst_ni         synchronous active-low clear of all registers
//   rs_addr_i      read port 1 index  -> rs_data_o (asynchronous)
//   rt_addr_i      read port 2 index  -> rt_data_o (asynchronous)
//   we_i/waddr_i/wdata_i  synchronous write port; writes to r0 are dropped
// r0 always reads zero.
// Build option DECODE_BYPASS_EN: read ports forward the write data of the
// current cycle when the indices match (non-zero). Without it, reads return
// the pre-write contents.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned XLEN  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  output logic [XLEN-1:0]   rs_data_o,
  output logic [XLEN-1:0]   rt_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rs_data_o = '0;
    rt_data_o = '0;
    if (rs_addr_i != '0) rs_data_o = regs_q[rs_addr_i];
    if (rt_addr_i != '0) rt_data_o = regs_q[rt_addr_i];
`ifdef DECODE_BYPASS_EN
    // wr_en already excludes r0, so r0 reads stay zero under forwarding
    if (wr_en && (waddr_i == rs_addr_i)) rs_data_o = wdata_i;
    if (wr_en && (waddr_i == rt_addr_i)) rt_data_o = wdata_i;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction-decode pipeline stage with ID/EX register.
//   clk, rst (synchronous, active-low)
//   if_id_instr / if_id_npc        : IF/ID pipeline register inputs
//   ex_mem_pc_src                  : taken branch, squashes decoded controls
//   mem_wb_reg_write / mem_wb_write_reg / wb_write_data : writeback port
//   id_ex_wb {reg_write, mem_to_reg}, id_ex_m {branch, mem_read, mem_write},
//   id_ex_ex {reg_dst, alu_op[1:0], alu_src}, id_ex_npc, id_ex_read_data1/2,
//   id_ex_sign_ext, id_ex_instr_2016 (rt), id_ex_instr_1511 (rd)
// Build option DECODE_BYPASS_EN: register-file write-to-read forwarding.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned XLEN  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_id_instr,
  input  logic [XLEN-1:0]   if_id_npc,
  input  logic              ex_mem_pc_src,
  input  logic              mem_wb_reg_write,
  input  logic [REG_AW-1:0] mem_wb_write_reg,
  input  logic [XLEN-1:0]   wb_write_data,
  output logic [WB_W-1:0]   id_ex_wb,
  output logic [M_W-1:0]    id_ex_m,
  output logic [EX_W-1:0]   id_ex_ex,
  output logic [XLEN-1:0]   id_ex_npc,
  output logic [XLEN-1:0]   id_ex_read_data1,
  output logic [XLEN-1:0]   id_ex_read_data2,
  output logic [XLEN-1:0]   id_ex_sign_ext,
  output logic [REG_AW-1:0] id_ex_instr_2016,
  output logic [REG_AW-1:0] id_ex_instr_1511
);

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [15:0]       imm;
  logic [XLEN-1:0]   rs_data, rt_data;

  assign opcode = if_id_instr[31:26];
  assign rs     = if_id_instr[25:21];
  assign rt     = if_id_instr[20:16];
  assign rd     = if_id_instr[15:11];
  assign imm    = if_id_instr[15:0];

  decode_regfile #(
    .NREGS (NREGS),
    .XLEN  (XLEN)
  ) u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst),
    .rs_addr_i (rs),
    .rt_addr_i (rt),
    .rs_data_o (rs_data),
    .rt_data_o (rt_data),
    .we_i      (mem_wb_reg_write),
    .waddr_i   (mem_wb_write_reg),
    .wdata_i   (wb_write_data)
  );

  ctrl_t             ctrl_d, ctrl_q;
  logic [XLEN-1:0]   npc_q, rd1_q, rd2_q, sext_d, sext_q;
  logic [REG_AW-1:0] rt_q, rd_q;

  always_comb begin
    ctrl_d = decode_ctrl(opcode);
    if (ex_mem_pc_src) ctrl_d = '0;
    sext_d = {{(XLEN-16){imm[15]}}, imm};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q <= '0;
      npc_q  <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      sext_q <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      npc_q  <= if_id_npc;
      rd1_q  <= rs_data;
      rd2_q  <= rt_data;
      sext_q <= sext_d;
      rt_q   <= rt;
      rd_q   <= rd;
    end
  end

  assign id_ex_wb         = ctrl_q.wb;
  assign id_ex_m          = ctrl_q.m;
  assign id_ex_ex         = ctrl_q.ex;
  assign id_ex_npc        = npc_q;
  assign id_ex_read_data1 = rd1_q;
  assign id_ex_read_data2 = rd2_q;
  assign id_ex_sign_ext   = sext_q;
  assign id_ex_instr_2016 = rt_q;
  assign id_ex_instr_1511 = rd_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: each issued cycle pushes its expected
// ID/EX contents (with a field mask); a monitor pops one entry per edge.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_id_instr, if_id_npc;
  logic        ex_mem_pc_src, mem_wb_reg_write;
  logic [4:0]  mem_wb_write_reg;
  logic [31:0] wb_write_data;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] id_ex_npc, id_ex_read_data1, id_ex_read_data2, id_ex_sign_ext;
  logic [4:0]  id_ex_instr_2016, id_ex_instr_1511;

  always #5 clk = ~clk;

  decode_stage #(.NREGS(32), .XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_id_instr      (if_id_instr),
    .if_id_npc        (if_id_npc),
    .ex_mem_pc_src    (ex_mem_pc_src),
    .mem_wb_reg_write (mem_wb_reg_write),
    .mem_wb_write_reg (mem_wb_write_reg),
    .wb_write_data    (wb_write_data),
    .id_ex_wb         (id_ex_wb),
    .id_ex_m          (id_ex_m),
    .id_ex_ex         (id_ex_ex),
    .id_ex_npc        (id_ex_npc),
    .id_ex_read_data1 (id_ex_read_data1),
    .id_ex_read_data2 (id_ex_read_data2),
    .id_ex_sign_ext   (id_ex_sign_ext),
    .id_ex_instr_2016 (id_ex_instr_2016),
    .id_ex_instr_1511 (id_ex_instr_1511)
  );

  // mask bits: 6 ctrl, 5 npc, 4 rd1, 3 rd2, 2 sext, 1 rt, 0 rd
  typedef struct {
    string       name;
    logic [6:0]  mask;
    logic [8:0]  ctrl;
    logic [31:0] npc, rd1, rd2, sext;
    logic [4:0]  rt, rd;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.mask[6]) chk({e.name, ".ctrl"}, {23'd0, id_ex_wb, id_ex_m, id_ex_ex}, {23'd0, e.ctrl});
      if (e.mask[5]) chk({e.name, ".npc"},  id_ex_npc, e.npc);
      if (e.mask[4]) chk({e.name, ".rd1"},  id_ex_read_data1, e.rd1);
      if (e.mask[3]) chk({e.name, ".rd2"},  id_ex_read_data2, e.rd2);
      if (e.mask[2]) chk({e.name, ".sext"}, id_ex_sign_ext, e.sext);
      if (e.mask[1]) chk({e.name, ".rt"},   {27'd0, id_ex_instr_2016}, {27'd0, e.rt});
      if (e.mask[0]) chk({e.name, ".rd"},   {27'd0, id_ex_instr_1511}, {27'd0, e.rd});
    end
  end

  // Drive one cycle of inputs, push its expectation, advance to the next negedge.
  task automatic issue(input logic r, input logic [31:0] instr, input logic [31:0] npc,
                       input logic pcsrc, input logic we, input logic [4:0] wreg,
                       input logic [31:0] wdata, input exp_t e);
    rst = r; if_id_instr = instr; if_id_npc = npc; ex_mem_pc_src = pcsrc;
    mem_wb_reg_write = we; mem_wb_write_reg = wreg; wb_write_data = wdata;
    sb.push_back(e);
    @(negedge clk);
  endtask

  function automatic exp_t mk(input string name, input logic [6:0] mask,
                              input logic [8:0] ctrl, input logic [31:0] npc,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] sext, input logic [4:0] rt,
                              input logic [4:0] rd);
    exp_t e;
    e.name = name; e.mask = mask; e.ctrl = ctrl; e.npc = npc;
    e.rd1 = rd1; e.rd2 = rd2; e.sext = sext; e.rt = rt; e.rd = rd;
    return e;
  endfunction

  localparam logic [31:0] NOP = 32'hFC00_0000;  // opcode 0x3F: bubble, rs=rt=0

  initial begin
    logic [31:0] same_cycle_r4;
`ifdef DECODE_BYPASS_EN
    same_cycle_r4 = 32'd9;
`else
    same_cycle_r4 = 32'd1;
`endif
    // reset held 2 cycles, with a writeback attempt that reset must override
    issue(0, 32'h8C22_0004, 32'h4, 1'b0, 1'b1, 5'd1, 32'h55,
          mk("rst0", 7'h7F, 9'h000, 0, 0, 0, 0, 0, 0));
    issue(0, 32'h8C22_0004, 32'h4, 1'b1, 1'b1, 5'd2, 32'h66,
          mk("rst1", 7'h7F, 9'h000, 0, 0, 0, 0, 0, 0));
    // r1/r2 read back 0 after release
    issue(1, 32'h0022_1820, 32'h8, 1'b0, 1'b0, 5'd0, 32'h0,
          mk("post_rst", 7'h7F, 9'b10_000_1100, 32'h8, 0, 0, 32'h1820, 5'd2, 5'd3));
    issue(1, NOP, 32'h0, 1'b0, 1'b1, 5'd1, 32'd5,
          mk("nop_wr1", 7'h40, 9'h000, 0, 0, 0, 0, 0, 0));
    issue(1, NOP, 32'h0, 1'b0, 1'b1, 5'd2, 32'd7,
          mk("nop_wr2", 7'h40, 9'h000, 0, 0, 0, 0, 0, 0));
    issue(1, 32'h0022_1820, 32'h10, 1'b0, 1'b0, 5'd0, 32'h0,
          mk("add", 7'h7F, 9'b10_000_1100, 32'h10, 32'd5, 32'd7, 32'h1820, 5'd2, 5'd3));
    issue(1, 32'h8C22_FFFC, 32'h14, 1'b0, 1'b0, 5'd0, 32'h0,
          mk("lw_neg", 7'h7F, 9'b11_010_0001, 32'h14, 32'd5, 32'd7, 32'hFFFF_FFFC, 5'd2, 5'd31));
    issue(1, 32'h1022_0003, 32'h18, 1'b1, 1'b0, 5'd0, 32'h0,
          mk("beq_flush", 7'h7F, 9'h000, 32'h18, 32'd5, 32'd7, 32'h3, 5'd2, 5'd0));
    issue(1, 32'h1022_0003, 32'h1C, 1'b0, 1'b0, 5'd0, 32'h0,
          mk("beq", 7'h7F, 9'b00_100_0010, 32'h1C, 32'd5, 32'd7, 32'h3, 5'd2, 5'd0));
    issue(1, 32'hAC22_0008, 32'h20, 1'b0, 1'b0, 5'd0, 32'h0,
          mk("sw", 7'h7F, 9'b00_001_0001, 32'h20, 32'd5, 32'd7, 32'h8, 5'd2, 5'd0));
    // r0 write dropped, including same-cycle forwarding
    issue(1, 32'h0000_0000, 32'h24, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF,
          mk("r0_same", 7'h58, 9'b10_000_1100, 0, 0, 0, 0, 0, 0));
    issue(1, 32'h0000_0000, 32'h28, 1'b0, 1'b0, 5'd0, 32'h0,
          mk("r0_after", 7'h18, 9'h000, 0, 0, 0, 0, 0, 0));
    // same-cycle write/read of r4
    issue(1, NOP, 32'h0, 1'b0, 1'b1, 5'd4, 32'd1,
          mk("wr_r4_1", 7'h40, 9'h000, 0, 0, 0, 0, 0, 0));
    issue(1, 32'h0084_2020, 32'h2C, 1'b0, 1'b1, 5'd4, 32'd9,
          mk("r4_same", 7'h18, 9'h000, 0, same_cycle_r4, same_cycle_r4, 0, 0, 0));
    issue(1, 32'h0084_2020, 32'h30, 1'b0, 1'b0, 5'd0, 32'h0,
          mk("r4_next", 7'h7F, 9'b10_000_1100, 32'h30, 32'd9, 32'd9, 32'h2020, 5'd4, 5'd4));
    // disabled writeback must not write r5
    issue(1, NOP, 32'h0, 1'b0, 1'b0, 5'd5, 32'h77,
          mk("we_off", 7'h40, 9'h000, 0, 0, 0, 0, 0, 0));
    issue(1, 32'h00A5_0000, 32'h34, 1'b0, 1'b0, 5'd0, 32'h0,
          mk("r5_read", 7'h18, 9'h000, 0, 0, 0, 0, 0, 0));
    // r31 boundary index
    issue(1, NOP, 32'h0, 1'b0, 1'b1, 5'd31, 32'h8000_0001,
          mk("wr_r31", 7'h40, 9'h000, 0, 0, 0, 0, 0, 0));
    issue(1, 32'h03E0_0000, 32'h38, 1'b0, 1'b0, 5'd0, 32'h0,
          mk("r31_read", 7'h10, 9'h000, 0, 32'h8000_0001, 0, 0, 0, 0));

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
